// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared states and register-bank constants for the operand reader
package reg_bank_pkg;

  // Operand read sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  // Architectural register indices with special meaning
  localparam int REG_ZERO     = 0;
  localparam int REG_SP       = 29;
  localparam int REG_RA       = 31;
  localparam int SP_RESET_DEF = 227;

endpackage

// File: rtl/reg_operand_reader_if.sv
// rtl/reg_operand_reader_if.sv - read request, commit/claim and status signals of the register bank
interface reg_operand_reader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  // Operand read handshake
  logic                 rd_req;
  logic [ADDR_W-1:0]    rs_addr;
  logic [ADDR_W-1:0]    rt_addr;
  logic                 rd_ack;
  logic [DATA_W-1:0]    reg_a;
  logic [DATA_W-1:0]    reg_b;
  logic                 busy;

  // Destination claim and write commit
  logic                 wr_claim;
  logic [ADDR_W-1:0]    claim_addr;
  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_addr;
  logic [DATA_W-1:0]    wr_data;

  // Status
  logic [2**ADDR_W-1:0] pending_mask;
  logic                 err_timeout;

  // Decode/writeback side drives requests and commits
  modport master (
    output rd_req, rs_addr, rt_addr,
    output wr_claim, claim_addr, wr_en, wr_addr, wr_data,
    input  rd_ack, reg_a, reg_b, busy, pending_mask, err_timeout
  );

  // Register bank side
  modport slave (
    input  rd_req, rs_addr, rt_addr,
    input  wr_claim, claim_addr, wr_en, wr_addr, wr_data,
    output rd_ack, reg_a, reg_b, busy, pending_mask, err_timeout
  );

endinterface

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - pending-write bit per register with two-port readiness query
module reg_scoreboard
  import reg_bank_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_claim,
  input  logic [ADDR_W-1:0]    claim_addr,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [ADDR_W-1:0]    qa_addr,
  input  logic [ADDR_W-1:0]    qb_addr,
  output logic [2**ADDR_W-1:0] pending_mask,
  output logic                 a_ready,
  output logic                 b_ready,
  output logic                 a_hit,
  output logic                 b_hit
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [2**ADDR_W-1:0] pend_q;
  logic                 commit;
  logic                 claim;

  // Register zero is hardwired, so neither claims nor commits to it count
  assign commit = wr_en && (wr_addr != ZERO_IDX);
  assign claim  = wr_claim && (claim_addr != ZERO_IDX);

  // Commit clears first, then claim sets, so a same-cycle claim leaves the bit set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      if (commit) pend_q[wr_addr] <= 1'b0;
      if (claim)  pend_q[claim_addr] <= 1'b1;
    end
  end

  // A commit arriving this cycle to a queried index satisfies it via bypass
  assign a_hit   = commit && (wr_addr == qa_addr);
  assign b_hit   = commit && (wr_addr == qb_addr);
  assign a_ready = (qa_addr == ZERO_IDX) || !pend_q[qa_addr] || a_hit;
  assign b_ready = (qb_addr == ZERO_IDX) || !pend_q[qb_addr] || b_hit;

  assign pending_mask = pend_q;

endmodule

// File: rtl/reg_operand_reader.sv
// rtl/reg_operand_reader.sv - register array and hazard-aware operand A/B fetch
module reg_operand_reader
  import reg_bank_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int SP_RESET = SP_RESET_DEF,
  parameter int WAIT_MAX = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  reg_operand_reader_if.slave  bus
);

  localparam int NREGS     = 2**ADDR_W;
  localparam int CNT_NEED  = $clog2(WAIT_MAX + 1);
  localparam int CNT_W     = (CNT_NEED > 8) ? CNT_NEED : 8;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(WAIT_MAX);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]    rs_q, rt_q;
  logic [DATA_W-1:0]    regs [NREGS];
  logic [DATA_W-1:0]    reg_a_q, reg_b_q;
  logic                 err_q;

  logic                 a_ready, b_ready, a_hit, b_hit;
  logic [NREGS-1:0]     pend;
  logic                 lat_addr, ld_ops, use_array, set_err;
  logic [DATA_W-1:0]    arr_a, arr_b, op_a, op_b;

  reg_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (reset),
    .wr_claim     (bus.wr_claim),
    .claim_addr   (bus.claim_addr),
    .wr_en        (bus.wr_en),
    .wr_addr      (bus.wr_addr),
    .qa_addr      (rs_q),
    .qb_addr      (rt_q),
    .pending_mask (pend),
    .a_ready      (a_ready),
    .b_ready      (b_ready),
    .a_hit        (a_hit),
    .b_hit        (b_hit)
  );

  // Stored values, with register zero forced to read as zero
  assign arr_a = (rs_q == ZERO_IDX) ? '0 : regs[rs_q];
  assign arr_b = (rt_q == ZERO_IDX) ? '0 : regs[rt_q];

  // A timeout takes whatever the array holds; otherwise prefer a same-cycle commit
  assign op_a = (!use_array && a_hit) ? bus.wr_data : arr_a;
  assign op_b = (!use_array && b_hit) ? bus.wr_data : arr_b;

  // Register array: commits land at the edge, register zero stays zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (i == REG_SP) ? DATA_W'(SP_RESET) : '0;
      end
    end else if (bus.wr_en && (bus.wr_addr != ZERO_IDX)) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // FSM state, stall counter and latched source indices
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (lat_addr) begin
        rs_q <= bus.rs_addr;
        rt_q <= bus.rt_addr;
      end
    end
  end

  // Next-state: wait until both sources are free of outstanding writes or the stall budget runs out
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lat_addr  = 1'b0;
    ld_ops    = 1'b0;
    use_array = 1'b0;
    set_err   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.rd_req) begin
          lat_addr = 1'b1;
          cnt_d    = '0;
          state_d  = CHECK;
        end
      end
      CHECK, WAIT: begin
        if (a_ready && b_ready) begin
          ld_ops  = 1'b1;
          state_d = ACK;
        end else if ((state_q == WAIT) && (cnt_q == CNT_MAX)) begin
          ld_ops    = 1'b1;
          use_array = 1'b1;
          set_err   = 1'b1;
          state_d   = ACK;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = WAIT;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand registers hold until the next load; the timeout flag is sticky
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_a_q <= '0;
      reg_b_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (ld_ops) begin
        reg_a_q <= op_a;
        reg_b_q <= op_b;
      end
      if (set_err) err_q <= 1'b1;
    end
  end

  assign bus.rd_ack       = (state_q == ACK);
  assign bus.busy         = (state_q != IDLE);
  assign bus.reg_a        = reg_a_q;
  assign bus.reg_b        = reg_b_q;
  assign bus.pending_mask = pend;
  assign bus.err_timeout  = err_q;

endmodule

// File: tb/tb_reg_operand_reader.sv
// tb/tb_reg_operand_reader.sv - directed bench with a cycle-level reference model of the register bank
module tb_reg_operand_reader;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int WAIT_MAX = 255;
  localparam int BOUND    = 400;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  reg_operand_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  reg_operand_reader #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .SP_RESET (227),
    .WAIT_MAX (WAIT_MAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the bank must look like, from its behavioural rules
  logic [31:0] m_regs [32];
  logic [31:0] m_pend;
  logic        m_err, m_active, m_ack;
  logic [31:0] m_a, m_b;
  logic [4:0]  m_rs, m_rt;
  int          m_age;
  logic        ok_a, ok_b;

  function automatic logic [31:0] m_arr(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : m_regs[a];
  endfunction

  function automatic logic m_commit_to(input logic [4:0] a);
    return bus.wr_en && (bus.wr_addr != 5'd0) && (bus.wr_addr == a);
  endfunction

  function automatic logic m_src_ok(input logic [4:0] a);
    return (a == 5'd0) || !m_pend[a] || m_commit_to(a);
  endfunction

  function automatic logic [31:0] m_src_val(input logic [4:0] a);
    return m_commit_to(a) ? bus.wr_data : m_arr(a);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_regs[29] = 32'd227;
      m_pend = 32'd0; m_err = 1'b0; m_active = 1'b0; m_ack = 1'b0;
      m_a = 32'd0; m_b = 32'd0; m_rs = 5'd0; m_rt = 5'd0; m_age = 0;
    end else begin
      if (m_ack) begin
        m_ack = 1'b0;
        m_active = 1'b0;
      end else if (m_active) begin
        ok_a = m_src_ok(m_rs);
        ok_b = m_src_ok(m_rt);
        if (ok_a && ok_b) begin
          m_a = m_src_val(m_rs); m_b = m_src_val(m_rt); m_ack = 1'b1;
        end else if (m_age == WAIT_MAX) begin
          m_err = 1'b1; m_a = m_arr(m_rs); m_b = m_arr(m_rt); m_ack = 1'b1;
        end else begin
          m_age++;
        end
      end else if (bus.rd_req) begin
        m_active = 1'b1; m_rs = bus.rs_addr; m_rt = bus.rt_addr; m_age = 0;
      end
      if (bus.wr_en && bus.wr_addr != 5'd0) begin
        m_regs[bus.wr_addr] = bus.wr_data;
        m_pend[bus.wr_addr] = 1'b0;
      end
      if (bus.wr_claim && bus.claim_addr != 5'd0) m_pend[bus.claim_addr] = 1'b1;
    end
  end

  // Compare every visible output against the model on each falling edge
  always @(negedge clk) begin
    if (!reset) begin
      chk("m_busy", 32'(bus.busy), 32'(m_active));
      chk("m_ack", 32'(bus.rd_ack), 32'(m_ack));
      chk("m_pend", bus.pending_mask, m_pend);
      chk("m_err", 32'(bus.err_timeout), 32'(m_err));
      chk("m_reg_a", bus.reg_a, m_a);
      chk("m_reg_b", bus.reg_b, m_b);
    end
  end

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt);
    @(posedge clk); #1;
    bus.rd_req = 1'b1; bus.rs_addr = rs; bus.rt_addr = rt;
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] rs, input logic [4:0] rt, output int n);
    issue(rs, rt);
    n = 0;
    while (n < BOUND) begin
      @(negedge clk);
      n++;
      if (bus.rd_ack) break;
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic do_claim(input logic [4:0] a);
    @(posedge clk); #1;
    bus.wr_claim = 1'b1; bus.claim_addr = a;
    @(posedge clk); #1;
    bus.wr_claim = 1'b0;
  endtask

  initial begin
    int n;
    bus.rd_req = 1'b0; bus.rs_addr = '0; bus.rt_addr = '0;
    bus.wr_claim = 1'b0; bus.claim_addr = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ack", 32'(bus.rd_ack), 32'd0);
    chk("rst_pend", bus.pending_mask, 32'd0);
    chk("rst_a", bus.reg_a, 32'd0);
    chk("rst_err", 32'(bus.err_timeout), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // stack pointer reset value, no hazard latency
    do_read(5'd29, 5'd0, n);
    chk("t1_lat", n, 32'd2);
    chk("t1_a", bus.reg_a, 32'd227);
    chk("t1_b", bus.reg_b, 32'd0);
    chk("t1_pend", bus.pending_mask, 32'd0);

    // committed value read back on both ports
    do_write(5'd8, 32'hDEADBEEF);
    do_read(5'd8, 5'd8, n);
    chk("t2_lat", n, 32'd2);
    chk("t2_a", bus.reg_a, 32'hDEADBEEF);
    chk("t2_b", bus.reg_b, 32'hDEADBEEF);

    // stall on pending source, released by a bypassed commit; extra request ignored
    do_claim(5'd9);
    chk("t3_pend", bus.pending_mask, 32'h0000_0200);
    issue(5'd9, 5'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_stall_ack", 32'(bus.rd_ack), 32'd0);
      chk("t3_stall_busy", 32'(bus.busy), 32'd1);
    end
    @(posedge clk); #1;
    bus.rd_req = 1'b1; bus.rs_addr = 5'd3;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h1234;
    @(posedge clk); #1;
    bus.rd_req = 1'b0; bus.wr_en = 1'b0;
    @(negedge clk);
    chk("t3_ack", 32'(bus.rd_ack), 32'd1);
    chk("t3_a", bus.reg_a, 32'h1234);
    chk("t3_b", bus.reg_b, 32'd0);
    @(negedge clk);
    chk("t3_ack_pulse", 32'(bus.rd_ack), 32'd0);
    chk("t3_not_queued", 32'(bus.busy), 32'd0);

    // register zero: claim and write ignored
    @(posedge clk); #1;
    bus.wr_claim = 1'b1; bus.claim_addr = 5'd0;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'hFFFF;
    @(posedge clk); #1;
    bus.wr_claim = 1'b0; bus.wr_en = 1'b0;
    do_read(5'd0, 5'd0, n);
    chk("t4_lat", n, 32'd2);
    chk("t4_a", bus.reg_a, 32'd0);
    chk("t4_pend", bus.pending_mask, 32'd0);

    // never-committed claim: timeout after WAIT_MAX stall cycles, stored value returned
    do_write(5'd10, 32'h55);
    do_claim(5'd10);
    do_read(5'd10, 5'd8, n);
    chk("t5_lat", n, 32'(WAIT_MAX + 2));
    chk("t5_err", 32'(bus.err_timeout), 32'd1);
    chk("t5_a", bus.reg_a, 32'h55);
    chk("t5_b", bus.reg_b, 32'hDEADBEEF);

    // reset while stalled takes effect immediately
    do_claim(5'd11);
    issue(5'd11, 5'd0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    #1;
    chk("t6_ack", 32'(bus.rd_ack), 32'd0);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_pend", bus.pending_mask, 32'd0);
    chk("t6_err", 32'(bus.err_timeout), 32'd0);
    chk("t6_a", bus.reg_a, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    do_read(5'd29, 5'd29, n);
    chk("t6_sp_a", bus.reg_a, 32'd227);
    chk("t6_sp_b", bus.reg_b, 32'd227);

    // claim and commit to the same index in one cycle: data lands, still pending
    @(posedge clk); #1;
    bus.wr_claim = 1'b1; bus.claim_addr = 5'd12;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd12; bus.wr_data = 32'h77;
    @(posedge clk); #1;
    bus.wr_claim = 1'b0; bus.wr_en = 1'b0;
    @(negedge clk);
    chk("t7_pend", bus.pending_mask, 32'h0000_1000);
    do_read(5'd12, 5'd0, n);
    chk("t7_lat", n, 32'(WAIT_MAX + 2));
    chk("t7_a", bus.reg_a, 32'h77);

    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
